// File: rtl/tile_layer_gen_if.sv
// Bus bundle between one tile-layer renderer, its tile-map RAM / graphics ROM
// ports and the colour mixer. "master" is the renderer side.
interface tile_layer_gen_if #(
   parameter int PLANES    = 3,
   parameter int CODE_W    = 10,
   parameter int PAL_W     = 4,
   parameter int COLS_LOG2 = 6,
   parameter int ROWS_LOG2 = 5
);
   logic                           ce_pix;
   logic                           line_start;
   logic [7:0]                     vpos;
   logic [COLS_LOG2+2:0]           hscroll;
   logic [ROWS_LOG2+2:0]           vscroll;
   logic                           screen_flip;
   logic [ROWS_LOG2+COLS_LOG2-1:0] map_addr;
   logic [15:0]                    map_data;
   logic [CODE_W+2:0]              rom_addr;
   logic [8*PLANES-1:0]            rom_data;
   logic [PAL_W+PLANES-1:0]        pixel_out;
   logic                           pixel_opaque;
   logic                           underrun;

   modport master (
      input  ce_pix, line_start, vpos, hscroll, vscroll, screen_flip,
      input  map_data, rom_data,
      output map_addr, rom_addr, pixel_out, pixel_opaque, underrun
   );

   modport slave (
      output ce_pix, line_start, vpos, hscroll, vscroll, screen_flip,
      output map_data, rom_data,
      input  map_addr, rom_addr, pixel_out, pixel_opaque, underrun
   );
endinterface

// File: rtl/tile_layer_gen.sv
// Tile-layer renderer: map/ROM fetch FSM feeding a one-tile prefetch buffer and
// a bitplane shifter with fine scroll, per-tile X-flip and full-screen flip.
module tile_layer_gen #(
   parameter int PLANES    = 3,
   parameter int CODE_W    = 10,
   parameter int PAL_W     = 4,
   parameter int COLS_LOG2 = 6,
   parameter int ROWS_LOG2 = 5,
   parameter bit XFLIP_EN  = 1'b1
) (
   input logic               master_clk,
   input logic               reset,
   tile_layer_gen_if.master  bus
);
   localparam int SY_W = ROWS_LOG2 + 3;
   localparam int HS_W = COLS_LOG2 + 3;
   localparam int DW   = 8 * PLANES;
   localparam logic [COLS_LOG2-1:0] COL_ONE = {{(COLS_LOG2-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MAP  = 3'd1,
      ST_ROM  = 3'd2,
      ST_FILL = 3'd3,
      ST_HOLD = 3'd4
   } state_t;

   // Mirror every plane byte so the shifter always emits bit 7 first.
   function automatic logic [DW-1:0] reverse_planes(input logic [DW-1:0] d);
      logic [DW-1:0] r;
      r = {DW{1'b0}};
      for (int p = 0; p < PLANES; p++) begin
         for (int b = 0; b < 8; b++) begin
            r[8*p+b] = d[8*p+7-b];
         end
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] shift_planes(input logic [DW-1:0] d);
      logic [DW-1:0] r;
      r = {DW{1'b0}};
      for (int p = 0; p < PLANES; p++) begin
         r[8*p +: 8] = {d[8*p +: 7], 1'b0};
      end
      return r;
   endfunction

   function automatic logic [PLANES-1:0] head_pixel(input logic [DW-1:0] d);
      logic [PLANES-1:0] px;
      px = {PLANES{1'b0}};
      for (int p = 0; p < PLANES; p++) begin
         px[p] = d[8*p+7];
      end
      return px;
   endfunction

   state_t                 state_r;
   state_t                 state_next_s;

   logic [SY_W-1:0]        sy_r;
   logic [COLS_LOG2-1:0]   col_r;
   logic [2:0]             skip_r;
   logic                   flip_r;

   logic [PAL_W-1:0]       tile_pal_r;
   logic                   tile_flip_r;
   logic [DW-1:0]          buf_data_r;
   logic [PAL_W-1:0]       buf_pal_r;
   logic                   buf_valid_r;

   logic [DW-1:0]          shift_r;
   logic [PAL_W-1:0]       shift_pal_r;
   logic [3:0]             cnt_r;
   logic [2:0]             skip_left_r;
   logic                   primed_r;

   logic [7:0]             vsel_s;
   logic [SY_W+7:0]        sy_sum_s;
   logic [SY_W-1:0]        sy_start_s;
   logic [2:0]             row_in_tile_s;
   logic [COLS_LOG2-1:0]   col_step_s;
   logic [CODE_W-1:0]      map_code_s;
   logic [PAL_W-1:0]       map_pal_s;
   logic                   map_xflip_s;
   logic [PLANES-1:0]      cur_pix_s;
   logic                   xfer_s;
   logic                   consume_s;
   logic                   skip_step_s;
   logic                   map_unused_s;

   assign vsel_s        = bus.screen_flip ? ~bus.vpos : bus.vpos;
   assign sy_sum_s      = {{SY_W{1'b0}}, vsel_s} + {8'd0, bus.vscroll};
   assign sy_start_s    = sy_sum_s[SY_W-1:0];
   assign row_in_tile_s = flip_r ? ~sy_r[2:0] : sy_r[2:0];
   assign col_step_s    = flip_r ? (col_r - COL_ONE) : (col_r + COL_ONE);
   assign map_code_s    = bus.map_data[CODE_W-1:0];
   assign map_pal_s     = bus.map_data[CODE_W+PAL_W-1:CODE_W];
   assign map_xflip_s   = XFLIP_EN ? bus.map_data[15] : 1'b0;
   assign map_unused_s  = ^bus.map_data;
   assign cur_pix_s     = head_pixel(shift_r);

   // The buffer moves into the shifter when the shifter is empty or its last pixel goes out now.
   assign xfer_s = buf_valid_r && !bus.line_start &&
                   ((cnt_r == 4'd0) || (bus.ce_pix && primed_r && (cnt_r == 4'd1)));
   assign consume_s   = bus.ce_pix && primed_r && (cnt_r != 4'd0) && !bus.line_start;
   assign skip_step_s = !primed_r && (cnt_r != 4'd0) && !bus.line_start;

   // Fetch FSM state register.
   always_ff @(posedge master_clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Fetch FSM next state: line_start restarts from MAP in any state.
   always_comb begin
      state_next_s = state_r;
      if (bus.line_start) begin
         state_next_s = ST_MAP;
      end else begin
         case (state_r)
            ST_IDLE: state_next_s = ST_IDLE;
            ST_MAP:  state_next_s = ST_ROM;
            ST_ROM:  state_next_s = ST_FILL;
            ST_FILL: state_next_s = ST_HOLD;
            ST_HOLD: begin
               if (xfer_s) begin
                  state_next_s = ST_MAP;
               end else begin
                  state_next_s = ST_HOLD;
               end
            end
            default: state_next_s = ST_IDLE;
         endcase
      end
   end

   // Per-line scroll context; the column walks one tile per transfer.
   always_ff @(posedge master_clk) begin
      if (reset) begin
         sy_r   <= {SY_W{1'b0}};
         col_r  <= {COLS_LOG2{1'b0}};
         skip_r <= 3'd0;
         flip_r <= 1'b0;
      end else if (bus.line_start) begin
         sy_r   <= sy_start_s;
         col_r  <= bus.hscroll[HS_W-1:3];
         skip_r <= bus.hscroll[2:0];
         flip_r <= bus.screen_flip;
      end else if (xfer_s) begin
         col_r  <= col_step_s;
      end
   end

   // Map/ROM address generation and prefetch buffer fill.
   always_ff @(posedge master_clk) begin
      if (reset) begin
         bus.map_addr <= {(ROWS_LOG2+COLS_LOG2){1'b0}};
         bus.rom_addr <= {(CODE_W+3){1'b0}};
         tile_pal_r   <= {PAL_W{1'b0}};
         tile_flip_r  <= 1'b0;
         buf_data_r   <= {DW{1'b0}};
         buf_pal_r    <= {PAL_W{1'b0}};
         buf_valid_r  <= 1'b0;
      end else if (bus.line_start) begin
         buf_valid_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_MAP: bus.map_addr <= {sy_r[SY_W-1:3], col_r};
            ST_ROM: begin
               bus.rom_addr <= {map_code_s, row_in_tile_s};
               tile_pal_r   <= map_pal_s;
               tile_flip_r  <= map_xflip_s ^ flip_r;
            end
            ST_FILL: begin
               buf_data_r  <= tile_flip_r ? reverse_planes(bus.rom_data) : bus.rom_data;
               buf_pal_r   <= tile_pal_r;
               buf_valid_r <= 1'b1;
            end
            ST_HOLD: begin
               if (xfer_s) begin
                  buf_valid_r <= 1'b0;
               end
            end
            default: buf_valid_r <= buf_valid_r;
         endcase
      end
   end

   // Pixel shifter: the first load of a line burns `skip` pixels before it is primed.
   always_ff @(posedge master_clk) begin
      if (reset) begin
         shift_r     <= {DW{1'b0}};
         shift_pal_r <= {PAL_W{1'b0}};
         cnt_r       <= 4'd0;
         skip_left_r <= 3'd0;
         primed_r    <= 1'b0;
      end else if (bus.line_start) begin
         cnt_r       <= 4'd0;
         skip_left_r <= 3'd0;
         primed_r    <= 1'b0;
      end else if (xfer_s) begin
         shift_r     <= buf_data_r;
         shift_pal_r <= buf_pal_r;
         cnt_r       <= 4'd8;
         if (!primed_r) begin
            skip_left_r <= skip_r;
            primed_r    <= (skip_r == 3'd0);
         end
      end else if (consume_s) begin
         shift_r <= shift_planes(shift_r);
         cnt_r   <= cnt_r - 4'd1;
      end else if (skip_step_s) begin
         shift_r     <= shift_planes(shift_r);
         cnt_r       <= cnt_r - 4'd1;
         skip_left_r <= skip_left_r - 3'd1;
         if (skip_left_r == 3'd1) begin
            primed_r <= 1'b1;
         end
      end
   end

   // Mixer-facing pixel, opaque flag and sticky underrun.
   always_ff @(posedge master_clk) begin
      if (reset) begin
         bus.pixel_out    <= {(PAL_W+PLANES){1'b0}};
         bus.pixel_opaque <= 1'b0;
         bus.underrun     <= 1'b0;
      end else if (bus.line_start) begin
         bus.underrun <= 1'b0;
         if (bus.ce_pix) begin
            bus.pixel_out    <= {(PAL_W+PLANES){1'b0}};
            bus.pixel_opaque <= 1'b0;
         end
      end else if (consume_s) begin
         bus.pixel_out    <= {shift_pal_r, cur_pix_s};
         bus.pixel_opaque <= (cur_pix_s != {PLANES{1'b0}});
         if ((cnt_r == 4'd1) && !buf_valid_r) begin
            bus.underrun <= 1'b1;
         end
      end else if (bus.ce_pix) begin
         bus.pixel_out    <= {(PAL_W+PLANES){1'b0}};
         bus.pixel_opaque <= 1'b0;
         bus.underrun     <= 1'b1;
      end
   end
endmodule

// File: tb/tb_tile_layer_gen.sv
// Scoreboard bench for tile_layer_gen: a reference pixel model fills the expected
// queue when a line is started; each ce_pix output pops and compares one entry.
module tb_tile_layer_gen;
   localparam int PLANES    = 3;
   localparam int CODE_W    = 10;
   localparam int PAL_W     = 4;
   localparam int COLS_LOG2 = 6;
   localparam int ROWS_LOG2 = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tile_layer_gen_if #(.PLANES(PLANES), .CODE_W(CODE_W), .PAL_W(PAL_W),
                       .COLS_LOG2(COLS_LOG2), .ROWS_LOG2(ROWS_LOG2)) bus ();

   tile_layer_gen #(.PLANES(PLANES), .CODE_W(CODE_W), .PAL_W(PAL_W),
                    .COLS_LOG2(COLS_LOG2), .ROWS_LOG2(ROWS_LOG2), .XFLIP_EN(1'b1)) dut (
      .master_clk (clk),
      .reset      (rst),
      .bus        (bus)
   );

   logic [15:0] map_mem [0:2047];
   logic [23:0] rom_mem [0:8191];

   assign bus.map_data = map_mem[bus.map_addr];
   assign bus.rom_data = rom_mem[bus.rom_addr];

   int n_checks = 0;
   int n_errors = 0;
   logic [6:0] exp_q [$];

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: expected {palette, pixel} stream for one line.
   task automatic push_line(input logic [8:0] hs, input logic [7:0] vs, input logic [7:0] vp,
                            input logic sf, input int npix);
      logic [7:0]  sy;
      logic [2:0]  r;
      logic [5:0]  col;
      logic [15:0] mw;
      logic [23:0] rd;
      logic [2:0]  px;
      logic        fl;
      int          b;
      int          bp;
      sy  = (sf ? ~vp : vp) + vs;
      r   = sf ? ~sy[2:0] : sy[2:0];
      col = hs[8:3];
      b   = int'(hs[2:0]);
      for (int i = 0; i < npix; i++) begin
         mw = map_mem[{sy[7:3], col}];
         fl = mw[15] ^ sf;
         rd = rom_mem[{mw[9:0], r}];
         bp = fl ? b : 7 - b;
         px = {rd[16+bp], rd[8+bp], rd[bp]};
         exp_q.push_back({mw[13:10], px});
         b++;
         if (b == 8) begin
            b   = 0;
            col = sf ? col - 6'd1 : col + 6'd1;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_line(input logic [8:0] hs, input logic [7:0] vs, input logic [7:0] vp,
                             input logic sf);
      bus.hscroll     = hs;
      bus.vscroll     = vs;
      bus.vpos        = vp;
      bus.screen_flip = sf;
      bus.line_start  = 1'b1;
      @(posedge clk);
      #1;
      bus.line_start  = 1'b0;
   endtask

   task automatic run_pixels(input int npix, input int duty, input string tag);
      int got;
      int cyc;
      logic [6:0] e;
      got = 0;
      cyc = 0;
      while (got < npix && cyc < npix * 20 + 50) begin
         bus.ce_pix = ($urandom_range(99) < duty) ? 1'b1 : 1'b0;
         @(posedge clk);
         #1;
         if (bus.ce_pix) begin
            e = exp_q.pop_front();
            check_value({tag, "_pix"}, 32'(bus.pixel_out), 32'(e));
            check_value({tag, "_opq"}, 32'(bus.pixel_opaque), 32'(e[2:0] != 3'd0));
            got++;
         end
         cyc++;
      end
      bus.ce_pix = 1'b0;
      if (got < npix) begin
         check_value({tag, "_timeout"}, 32'(got), 32'(npix));
      end
   endtask

   initial begin
      logic [8:0] hs;
      logic [7:0] vs;
      logic [7:0] vp;
      logic       sf;
      rst             = 1'b1;
      bus.ce_pix      = 1'b0;
      bus.line_start  = 1'b0;
      bus.vpos        = 8'd0;
      bus.hscroll     = 9'd0;
      bus.vscroll     = 8'd0;
      bus.screen_flip = 1'b0;
      for (int i = 0; i < 2048; i++) map_mem[i] = 16'($urandom);
      for (int i = 0; i < 8192; i++) rom_mem[i] = 24'($urandom);
      map_mem[0]       = 16'h2C05;
      rom_mem[13'h028] = 24'hFF0080;

      idle(3);
      rst = 1'b0;
      idle(1);
      check_value("rst_pixel", 32'(bus.pixel_out), 32'd0);
      check_value("rst_opaque", 32'(bus.pixel_opaque), 32'd0);
      check_value("rst_underrun", 32'(bus.underrun), 32'd0);
      check_value("rst_map_addr", 32'(bus.map_addr), 32'd0);
      check_value("rst_rom_addr", 32'(bus.rom_addr), 32'd0);

      // Basic fetch: tile 5, palette 0xB
      start_line(9'd0, 8'd0, 8'd0, 1'b0);
      push_line(9'd0, 8'd0, 8'd0, 1'b0, 16);
      idle(1);
      check_value("basic_map_addr", 32'(bus.map_addr), 32'h000);
      idle(1);
      check_value("basic_rom_addr", 32'(bus.rom_addr), 32'h028);
      idle(10);
      bus.ce_pix = 1'b1;
      idle(1);
      bus.ce_pix = 1'b0;
      check_value("basic_first_pixel", 32'(bus.pixel_out), 32'h5D);
      void'(exp_q.pop_front());
      run_pixels(15, 100, "basic");
      check_value("basic_underrun", 32'(bus.underrun), 32'd0);

      // Fine scroll
      start_line(9'd3, 8'd0, 8'd0, 1'b0);
      push_line(9'd3, 8'd0, 8'd0, 1'b0, 13);
      idle(12);
      run_pixels(13, 100, "fine");

      // X-flip, then screen flip on top
      map_mem[0]             = 16'hAC05;
      map_mem[{5'd31, 6'd0}] = 16'hAC05;
      start_line(9'd0, 8'd0, 8'd0, 1'b0);
      push_line(9'd0, 8'd0, 8'd0, 1'b0, 16);
      idle(12);
      run_pixels(16, 100, "xflip");
      start_line(9'd0, 8'd0, 8'd0, 1'b1);
      push_line(9'd0, 8'd0, 8'd0, 1'b1, 16);
      idle(12);
      run_pixels(16, 100, "sflip");

      // Column wrap with vertical wrap to row 0
      start_line(9'h1F8, 8'hFF, 8'd1, 1'b0);
      push_line(9'h1F8, 8'hFF, 8'd1, 1'b0, 16);
      idle(1);
      check_value("wrap_map_addr0", 32'(bus.map_addr), 32'd63);
      idle(1);
      check_value("wrap_rom_addr", 32'(bus.rom_addr), 32'({map_mem[63][9:0], 3'd0}));
      idle(3);
      check_value("wrap_map_addr1", 32'(bus.map_addr), 32'd0);
      idle(7);
      run_pixels(16, 100, "wrap");

      // Random scroll/flip lines with sparse and full duty
      for (int k = 0; k < 4; k++) begin
         hs = 9'($urandom);
         vs = 8'($urandom);
         vp = 8'($urandom);
         sf = 1'($urandom);
         start_line(hs, vs, vp, sf);
         push_line(hs, vs, vp, sf, 40);
         idle(12);
         run_pixels(40, (k == 0) ? 100 : 55, "rand");
         check_value("rand_underrun", 32'(bus.underrun), 32'd0);
      end

      // Underrun: pixel requested right after line_start, sticky until next line
      start_line(9'd0, 8'd0, 8'd0, 1'b0);
      push_line(9'd0, 8'd0, 8'd0, 1'b0, 8);
      idle(12);
      run_pixels(8, 100, "pre_udr");
      start_line(9'd0, 8'd0, 8'd0, 1'b0);
      bus.ce_pix = 1'b1;
      idle(1);
      bus.ce_pix = 1'b0;
      check_value("udr_pixel", 32'(bus.pixel_out), 32'd0);
      check_value("udr_opaque", 32'(bus.pixel_opaque), 32'd0);
      check_value("udr_flag", 32'(bus.underrun), 32'd1);
      idle(20);
      check_value("udr_sticky", 32'(bus.underrun), 32'd1);
      start_line(9'd0, 8'd0, 8'd0, 1'b0);
      check_value("udr_cleared", 32'(bus.underrun), 32'd0);

      // line_start together with ce_pix forces a blank pixel
      push_line(9'd0, 8'd0, 8'd0, 1'b0, 8);
      idle(11);
      run_pixels(8, 100, "pre_ls");
      bus.ce_pix = 1'b1;
      start_line(9'd0, 8'd0, 8'd0, 1'b0);
      bus.ce_pix = 1'b0;
      check_value("ls_ce_pixel", 32'(bus.pixel_out), 32'd0);
      check_value("ls_ce_underrun", 32'(bus.underrun), 32'd0);

      // Reset mid-line with ce_pix held high
      start_line(9'h1F8, 8'd0, 8'd9, 1'b0);
      push_line(9'h1F8, 8'd0, 8'd9, 1'b0, 8);
      idle(12);
      run_pixels(5, 100, "pre_rst");
      exp_q.delete();
      bus.ce_pix = 1'b1;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      bus.ce_pix = 1'b0;
      idle(1);
      check_value("mid_rst_pixel", 32'(bus.pixel_out), 32'd0);
      check_value("mid_rst_opaque", 32'(bus.pixel_opaque), 32'd0);
      check_value("mid_rst_underrun", 32'(bus.underrun), 32'd0);
      check_value("mid_rst_map_addr", 32'(bus.map_addr), 32'd0);
      check_value("mid_rst_rom_addr", 32'(bus.rom_addr), 32'd0);
      idle(6);
      check_value("mid_rst_idle_map", 32'(bus.map_addr), 32'd0);

      // Recovery line after reset
      start_line(9'd5, 8'd17, 8'd40, 1'b0);
      push_line(9'd5, 8'd17, 8'd40, 1'b0, 24);
      idle(12);
      run_pixels(24, 100, "recover");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
